// File: rtl/rvfpm_pkg.sv
// Shared types and constants for the rvfpm pipeline controller.
package rvfpm_pkg;

    parameter int FLEN       = 32;
    parameter int X_ID_WIDTH = 4;
    parameter int NUM_REGS   = 32;

    localparam int FP_REG_AW = $clog2(NUM_REGS);
    localparam int REG_IDX_W = 5;

    localparam int RD_LSB  = 7;
    localparam int RS1_LSB = 15;
    localparam int RS2_LSB = 20;
    localparam int RS3_LSB = 27;

    typedef struct packed {
        logic                  valid;
        logic [X_ID_WIDTH-1:0] id;
        logic [REG_IDX_W-1:0]  rd;
        logic                  we;
        logic [FLEN-1:0]       data;
    } stage_t;

endpackage

// File: rtl/rvfpm_hazard_chk.sv
// Read-after-write hazard detect: any used source matching a valid in-flight writer.
module rvfpm_hazard_chk
    import rvfpm_pkg::*;
#(
    parameter int NUM_STAGES = 4,
    parameter int AW         = FP_REG_AW
) (
    input  logic [2:0][AW-1:0]          rs_idx_i,
    input  logic [2:0]                  rs_used_i,
    input  logic [NUM_STAGES-1:0]       stage_valid_i,
    input  logic [NUM_STAGES-1:0]       stage_we_i,
    input  logic [NUM_STAGES-1:0][AW-1:0] stage_rd_i,
    output logic                        hazard_o
);

    // The retiring stage is included on purpose: there is no result bypass.
    always_comb begin
        hazard_o = 1'b0;
        for (int s = 0; s < 3; s++) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                if (rs_used_i[s] && stage_valid_i[k] && stage_we_i[k] &&
                    (stage_rd_i[k] == rs_idx_i[s])) begin
                    hazard_o = 1'b1;
                end
            end
        end
    end

endmodule

// File: rtl/rvfpm_pipe_ctrl.sv
// In-order issue/retire pipeline for the rvfpm FP model: delays model results by
// PIPELINE_STAGES with bubble-collapsing backpressure, RAW scoreboard and flush.
module rvfpm_pipe_ctrl
    import rvfpm_pkg::*;
#(
    parameter int PIPELINE_STAGES = 4,
    parameter int NUM_REGS        = rvfpm_pkg::NUM_REGS,
    parameter int FLEN            = rvfpm_pkg::FLEN,
    parameter int X_ID_WIDTH      = rvfpm_pkg::X_ID_WIDTH
) (
    input  logic                                   ck,
    input  logic                                   rst,
    input  logic                                   issue_valid,
    output logic                                   issue_ready,
    input  logic [X_ID_WIDTH-1:0]                  issue_id,
    input  logic [31:0]                            issue_instr,
    input  logic [2:0]                             issue_rs_used,
    input  logic                                   issue_rd_we,
    input  logic [FLEN-1:0]                        exec_result,
    input  logic                                   flush,
    output logic                                   result_valid,
    input  logic                                   result_ready,
    output logic [X_ID_WIDTH-1:0]                  result_id,
    output logic [4:0]                             result_rd,
    output logic                                   result_we,
    output logic [FLEN-1:0]                        result_data,
    output logic                                   busy,
    output logic [$clog2(PIPELINE_STAGES+1)-1:0]   occupancy
);

    localparam int LAST  = PIPELINE_STAGES - 1;
    localparam int OCC_W = $clog2(PIPELINE_STAGES + 1);
    localparam int AW    = $clog2(NUM_REGS);

    logic                                valid_vec;
    logic [PIPELINE_STAGES-1:0]          stage_valid;
    logic [PIPELINE_STAGES-1:0]          stage_we;
    logic [PIPELINE_STAGES-1:0][AW-1:0]  stage_rd;
    logic [2:0][AW-1:0]                  rs_idx;
    logic                                hazard;
    logic                                issue_accept;
    logic [OCC_W-1:0]                    occ_d;
    logic                                unused_instr;

    assign issue_accept = issue_valid & issue_ready;

    // Each stage computes whether it can take a new entry (free_s) and whether its
    // own entry moves on (adv_s); the chain runs combinationally from the tail.
    for (genvar k = 0; k < PIPELINE_STAGES; k++) begin : gen_stage
        stage_t stage_q;
        stage_t stage_d;
        stage_t in_data;
        logic   in_valid;
        logic   adv_s;
        logic   free_s;

        if (k == LAST) begin : g_tail
            assign adv_s = stage_q.valid & result_ready;
        end else begin : g_mid
            assign adv_s = stage_q.valid & gen_stage[k+1].free_s;
        end

        assign free_s = ~stage_q.valid | adv_s;

        if (k == 0) begin : g_head
            assign in_valid = issue_accept;
            assign in_data  = '{valid: 1'b1,
                                id:    issue_id,
                                rd:    issue_instr[RD_LSB +: REG_IDX_W],
                                we:    issue_rd_we,
                                data:  exec_result};
        end else begin : g_body
            assign in_valid = gen_stage[k-1].adv_s;
            assign in_data  = gen_stage[k-1].stage_q;
        end

        always_comb begin
            stage_d = stage_q;
            if (free_s) begin
                if (in_valid) begin
                    stage_d = in_data;
                end
                stage_d.valid = in_valid;
            end
            if (flush) begin
                stage_d.valid = 1'b0;
            end
        end

        // Only the valid bit is reset; payload is don't-care while invalid.
        always_ff @(posedge ck or posedge rst) begin
            if (rst) begin
                stage_q.valid <= 1'b0;
            end else begin
                stage_q <= stage_d;
            end
        end

        assign stage_valid[k] = stage_q.valid;
        assign stage_we[k]    = stage_q.we;
        assign stage_rd[k]    = stage_q.rd[AW-1:0];
    end

    assign rs_idx[0] = issue_instr[RS1_LSB +: AW];
    assign rs_idx[1] = issue_instr[RS2_LSB +: AW];
    assign rs_idx[2] = issue_instr[RS3_LSB +: AW];

    rvfpm_hazard_chk #(
        .NUM_STAGES (PIPELINE_STAGES),
        .AW         (AW)
    ) u_hazard_chk (
        .rs_idx_i      (rs_idx),
        .rs_used_i     (issue_rs_used),
        .stage_valid_i (stage_valid),
        .stage_we_i    (stage_we),
        .stage_rd_i    (stage_rd),
        .hazard_o      (hazard)
    );

    assign issue_ready = gen_stage[0].free_s & ~hazard & ~flush;

    always_comb begin
        occ_d = '0;
        for (int k = 0; k < PIPELINE_STAGES; k++) begin
            occ_d = occ_d + OCC_W'(stage_valid[k]);
        end
    end

    assign valid_vec = |stage_valid;
    assign occupancy = occ_d;
    assign busy      = valid_vec;

    assign result_valid = gen_stage[LAST].stage_q.valid;
    assign result_id    = gen_stage[LAST].stage_q.id;
    assign result_rd    = gen_stage[LAST].stage_q.rd;
    assign result_we    = gen_stage[LAST].stage_q.we;
    assign result_data  = gen_stage[LAST].stage_q.data;

    assign unused_instr = ^{issue_instr[6:0], issue_instr[14:12], issue_instr[26:25]};

endmodule

// File: tb/tb_rvfpm_pipe_ctrl.sv
// Scoreboard bench for rvfpm_pipe_ctrl: driver pushes expected results, monitor pops on retire.
module tb_rvfpm_pipe_ctrl;

    localparam int NS   = 4;
    localparam int FL   = 32;
    localparam int IDW  = 4;
    localparam int OCCW = $clog2(NS + 1);

    logic            ck = 1'b0;
    logic            rst = 1'b1;
    logic            issue_valid = 1'b0;
    logic            issue_ready;
    logic [IDW-1:0]  issue_id = '0;
    logic [31:0]     issue_instr = '0;
    logic [2:0]      issue_rs_used = '0;
    logic            issue_rd_we = 1'b0;
    logic [FL-1:0]   exec_result = '0;
    logic            flush = 1'b0;
    logic            result_valid;
    logic            result_ready = 1'b0;
    logic [IDW-1:0]  result_id;
    logic [4:0]      result_rd;
    logic            result_we;
    logic [FL-1:0]   result_data;
    logic            busy;
    logic [OCCW-1:0] occupancy;

    rvfpm_pipe_ctrl #(
        .PIPELINE_STAGES (NS),
        .NUM_REGS        (32),
        .FLEN            (FL),
        .X_ID_WIDTH      (IDW)
    ) dut (
        .ck            (ck),
        .rst           (rst),
        .issue_valid   (issue_valid),
        .issue_ready   (issue_ready),
        .issue_id      (issue_id),
        .issue_instr   (issue_instr),
        .issue_rs_used (issue_rs_used),
        .issue_rd_we   (issue_rd_we),
        .exec_result   (exec_result),
        .flush         (flush),
        .result_valid  (result_valid),
        .result_ready  (result_ready),
        .result_id     (result_id),
        .result_rd     (result_rd),
        .result_we     (result_we),
        .result_data   (result_data),
        .busy          (busy),
        .occupancy     (occupancy)
    );

    always #5 ck = ~ck;

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [4:0]     rd;
        logic           we;
        logic [FL-1:0]  data;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail = 0;
    int   retire_cnt = 0;
    time  last_retire_t = 0;
    time  last_accept_t = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mk_instr(input logic [4:0] rd, input logic [4:0] rs1,
                                             input logic [4:0] rs2, input logic [4:0] rs3);
        return {rs3, 2'b00, rs2, rs1, 3'b000, rd, 7'b1010011};
    endfunction

    // Monitor: every handshaked result must match the oldest outstanding issue.
    always @(negedge ck) begin : monitor
        exp_t act_e;
        exp_t exp_e;
        if (!rst && result_valid && result_ready) begin
            act_e = '{result_id, result_rd, result_we, result_data};
            if (sb.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_result: got id %0d with nothing outstanding", result_id);
            end else begin
                exp_e = sb.pop_front();
                chk("retire", act_e, exp_e);
            end
            last_retire_t = $time;
            retire_cnt++;
        end
    end

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic issue(input logic [IDW-1:0] id, input logic [4:0] rd, input logic [4:0] rs1,
                         input logic [4:0] rs2, input logic [4:0] rs3, input logic [2:0] used,
                         input logic we, input logic [FL-1:0] data);
        int n = 0;
        issue_valid   = 1'b1;
        issue_id      = id;
        issue_instr   = mk_instr(rd, rs1, rs2, rs3);
        issue_rs_used = used;
        issue_rd_we   = we;
        exec_result   = data;
        @(negedge ck);
        while (!issue_ready && n < 50) begin
            @(negedge ck);
            n++;
        end
        if (!issue_ready) begin
            n_tests++;
            n_fail++;
            $display("FAIL issue_timeout: id %0d never accepted", id);
        end else begin
            sb.push_back('{id, rd, we, data});
            last_accept_t = $time;
        end
        @(posedge ck);
        #1;
        issue_valid = 1'b0;
    endtask

    task automatic wait_idle();
        int n = 0;
        @(negedge ck);
        while (busy && n < 60) begin
            @(negedge ck);
            n++;
        end
        chk("drain_idle", busy, 1'b0);
        @(posedge ck);
        #1;
    endtask

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : stim
        int   lat;
        int   cnt;
        int   r0;
        time  t1;

        // Reset values
        #12;
        chk("rst_result_valid", result_valid, 1'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_occupancy", occupancy, 0);
        @(posedge ck); #1;
        rst = 1'b0;
        @(negedge ck);
        chk("rst_issue_ready", issue_ready, 1'b1);
        @(posedge ck); #1;

        // Latency: id 3, rd 5, 1.0f
        result_ready = 1'b1;
        issue(4'd3, 5'd5, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h3F80_0000);
        lat = 0;
        for (int n = 1; n <= 10; n++) begin
            @(negedge ck);
            if (result_valid) begin
                lat = n;
                break;
            end
        end
        chk("latency", lat, 4);
        @(negedge ck);
        chk("latency_one_cycle", result_valid, 1'b0);
        @(posedge ck); #1;

        // Backpressure fill then drain in order, one per cycle
        result_ready = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            issue(IDW'(i), 5'(10 + i), 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h1000_0000 + i);
        end
        @(negedge ck);
        chk("fill_occupancy", occupancy, 4);
        chk("fill_issue_ready", issue_ready, 1'b0);
        chk("fill_busy", busy, 1'b1);
        @(posedge ck); #1;
        r0 = retire_cnt;
        result_ready = 1'b1;
        #1;
        chk("fill_ready_comb", issue_ready, 1'b1);
        repeat (4) @(posedge ck);
        #1;
        chk("fill_drain_rate", retire_cnt - r0, 4);
        chk("fill_drained_occ", occupancy, 0);

        // Bubble collapse: issue at T and T+2, stall the tail from T+3
        issue(4'd5, 5'd20, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'hAAAA_0005);
        @(posedge ck); #1;
        issue(4'd6, 5'd21, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'hAAAA_0006);
        result_ready = 1'b0;
        repeat (3) @(posedge ck);
        @(negedge ck);
        chk("bubble_occupancy", occupancy, 2);
        chk("bubble_issue_ready", issue_ready, 1'b1);
        @(posedge ck); #1;
        result_ready = 1'b1;
        @(posedge ck); #1;
        @(negedge ck);
        chk("bubble_next_in_tail", result_valid, 1'b1);
        wait_idle();

        // Hazard: rs2 depends on in-flight rd 7 with we=1
        issue(4'd7, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h4000_0000);
        issue(4'd8, 5'd8, 5'd0, 5'd7, 5'd7, 3'b010, 1'b1, 32'h4040_0000);
        chk("hazard_stall_until_retire", last_accept_t - last_retire_t, 10);
        wait_idle();

        // Same with we=0 on the producer: back-to-back accept
        issue(4'd9, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b0, 32'h4080_0000);
        t1 = last_accept_t;
        issue(4'd10, 5'd9, 5'd0, 5'd7, 5'd0, 3'b010, 1'b1, 32'h40A0_0000);
        chk("no_hazard_we0", last_accept_t - t1, 10);
        wait_idle();

        // Matching index on an unused source does not stall
        issue(4'd11, 5'd7, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h40C0_0000);
        t1 = last_accept_t;
        issue(4'd12, 5'd10, 5'd7, 5'd7, 5'd3, 3'b100, 1'b1, 32'h40E0_0000);
        chk("no_hazard_unused_rs", last_accept_t - t1, 10);
        wait_idle();

        // Flush with three in flight and an issue pending
        result_ready = 1'b0;
        issue(4'd13, 5'd1, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h5000_0001);
        issue(4'd14, 5'd2, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h5000_0002);
        issue(4'd15, 5'd3, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h5000_0003);
        flush         = 1'b1;
        issue_valid   = 1'b1;
        issue_id      = 4'd1;
        issue_instr   = mk_instr(5'd4, 5'd0, 5'd0, 5'd0);
        issue_rs_used = 3'b000;
        @(negedge ck);
        chk("flush_issue_ready", issue_ready, 1'b0);
        @(posedge ck); #1;
        flush       = 1'b0;
        issue_valid = 1'b0;
        sb.delete();
        @(negedge ck);
        chk("flush_occupancy", occupancy, 0);
        chk("flush_result_valid", result_valid, 1'b0);
        @(posedge ck); #1;
        result_ready = 1'b1;
        cnt = 0;
        repeat (8) begin
            @(negedge ck);
            if (result_valid) cnt++;
        end
        chk("flush_no_results", cnt, 0);
        @(posedge ck); #1;

        // Asynchronous reset mid-cycle with two in flight
        result_ready = 1'b0;
        issue(4'd2, 5'd12, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h6000_0002);
        issue(4'd3, 5'd13, 5'd0, 5'd0, 5'd0, 3'b000, 1'b1, 32'h6000_0003);
        repeat (3) @(posedge ck);
        #2;
        chk("pre_reset_valid", result_valid, 1'b1);
        chk("pre_reset_occ", occupancy, 2);
        rst = 1'b1;
        #1;
        chk("async_rst_result_valid", result_valid, 1'b0);
        chk("async_rst_busy", busy, 1'b0);
        chk("async_rst_occupancy", occupancy, 0);
        sb.delete();
        @(posedge ck); #1;
        rst = 1'b0;
        @(negedge ck);
        chk("post_reset_issue_ready", issue_ready, 1'b1);
        @(posedge ck); #1;
        result_ready = 1'b1;
        issue(4'd4, 5'd31, 5'd1, 5'd2, 5'd3, 3'b111, 1'b1, 32'hDEAD_BEEF);
        wait_idle();

        chk("scoreboard_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/rvfpm_pipe_ctrl.md
# rvfpm_pipe_ctrl

Parametrised in-order issue/retire pipeline controller for the rvfpm floating-point model. It replaces the fixed single-call wrapper with a `PIPELINE_STAGES`-deep tracked pipeline. The pipeline has:
- a valid/ready issue port and a valid/ready result port;
- bubble-collapsing backpressure;
- a register-hazard scoreboard;
- a synchronous flush.

It sits between the core-side CORE-V-XIF adapter and the FP execution model. The model computes `exec_result` combinationally from the issue fields; this block only sequences, delays and orders the results.

## Interface
- `PIPELINE_STAGES`, 4, result latency in stages (≥1)
- `NUM_REGS`, 32, FP register count (≤32, power of two)
- `FLEN`, 32, result data width
- `X_ID_WIDTH`, 4, instruction id width
- `ck` in 1, clock, rising edge
- `rst` in 1, asynchronous, active-high reset
- `issue_valid` in 1, issue request
- `issue_ready` out 1, issue accepted when both valid and ready are high
- `issue_id` in `X_ID_WIDTH`, instruction id
- `issue_instr` in 32, instruction; rd=[11:7], rs1=[19:15], rs2=[24:20], rs3=[31:27]
- `issue_rs_used` in 3, bit0/1/2 = rs1/rs2/rs3 is an FP source
- `issue_rd_we` in 1, instruction writes FP rd
- `exec_result` in `FLEN`, model result for the current issue fields, captured on accept
- `flush` in 1, kill all in-flight entries
- `result_valid` out 1, last stage holds an entry
- `result_ready` in 1, consumer accepts the result
- `result_id` out `X_ID_WIDTH`
- `result_rd` out 5
- `result_we` out 1
- `result_data` out `FLEN`
- `busy` out 1, any stage valid
- `occupancy` out `$clog2(PIPELINE_STAGES+1)`, count of valid stages

## Operation
- **Stages:** 0 … `PIPELINE_STAGES`-1. Each stage holds valid, id, rd, we and data. Only the valid bits are reset; payload registers are not.
- **Advance rule:** stage k advances when:
  - the stage after it is empty or itself advancing; for the last stage, "advancing" means `result_ready` is high.
  - Bubbles collapse: a stalled tail does not block entries upstream of an empty stage.
- **Accept rule:** `issue_ready` = stage 0 empty or advancing, AND no hazard, AND `flush` low.
- **Capture on accept:** stage 0 captures `issue_id`, rd, `issue_rd_we` and `exec_result`.
- **Hazard:** for each used rs (low `$clog2(NUM_REGS)` bits), a hazard exists if any valid stage has we=1 and rd equal to that rs.
  - The stage retiring this cycle still counts; there is no bypass.
  - `issue_rd_we`=0 entries never cause hazards.
- **Retire:** a result retires when `result_valid` and `result_ready` are both high. `result_*` outputs are driven directly from the last stage's registers. Retire order equals issue order.
- **Flush:** on the clock edge with `flush`=1, all valid bits clear.
  - No issue is accepted that cycle.
  - A result handshaking in the same cycle still counts as retired.
- **Occupancy:** `occupancy` = popcount of the valid bits; `busy` = (`occupancy` ≠ 0).
- **Reset values:** `rst` clears all valid bits asynchronously. `result_valid`=0, `busy`=0, `occupancy`=0; `issue_ready`=1 once `rst` deasserts.

## Timing
- **Latency:** an issue accepted at edge T (no stalls) gives `result_valid`=1 in cycle T+`PIPELINE_STAGES`.
- **Throughput:** 1 issue per cycle when `result_ready` is held high and there are no hazards.
- **Full pipeline:** all stages valid and `result_ready`=0 → `issue_ready`=0.
  - When `result_ready` rises, `issue_ready` is 1 in the same cycle (combinational through the advance chain).
- **Dependent issue:** with the producer in the last stage, the dependent issue is accepted in the cycle after the producer retires.
- **Output stability:** `result_*` are stable while `result_valid`=1 and `result_ready`=0.
- **Reset mid-operation:** all in-flight entries are lost; no `result_valid` pulse occurs.
- **`PIPELINE_STAGES`=1:** the single stage behaves as a skid-less register slice with the same rules.

## Structure
- **Package `rvfpm_pkg`:**
  - instruction field position constants (rd/rs1/rs2/rs3 LSB);
  - stage entry struct typedef (valid, id, rd, we, data), parametrised via package parameters `FLEN` and `X_ID_WIDTH`;
  - `FP_REG_AW` = `$clog2(NUM_REGS)`.
- **Sub-module `rvfpm_hazard_chk`:** combinational; compares 3 source indices plus the used mask against all stage rd/we/valid and outputs `hazard`. It is instantiated once.
- **Generate loop:** stage registers and advance logic are built in a generate loop inside `rvfpm_pipe_ctrl`.

## Test plan
- **Latency:** `PIPELINE_STAGES`=4, `result_ready`=1; issue id 3, rd 5, `exec_result`=0x3F800000 at edge T → cycle T+4 shows `result_valid`=1, id 3, rd 5, data 0x3F800000 for exactly one cycle.
- **Backpressure fill:** `result_ready`=0 with back-to-back issues → 4 accepted, `occupancy`=4, `issue_ready`=0. Raise `result_ready` → ids retire in issue order, one per cycle.
- **Bubble collapse:** issue at T and T+2, `result_ready` low from T+3 → the second entry moves up to stage 2. `occupancy`=2 and `issue_ready`=1.
- **Hazard:** issue rd 7 with we=1, then issue rs2 7 with `issue_rs_used`=3'b010 → second issue stalls until the cycle after the first retires. The same case with we=0 on the first issue gives no stall.
- **Flush:** 3 in flight, `flush` pulsed for one cycle with `issue_valid`=1 → `issue_ready`=0 that cycle; next cycle `occupancy`=0 and no `result_valid` ever appears for the flushed ids.
- **Async reset:** assert `rst` mid-cycle with 2 in flight → `result_valid`, `busy` and `occupancy` go to 0 immediately, without waiting for `ck`.
